// File: rtl/lcd_frame_assembler_if.sv
// Byte-in / frame-out bundle between the UART receiver side and the LCD driver side.
interface lcd_frame_assembler_if #(
    parameter int unsigned BYTE_W  = 8,
    parameter int unsigned N_BYTES = 32
) ();
    localparam int unsigned CntW = $clog2(N_BYTES + 1);

    logic                      i_valid;
    logic [BYTE_W-1:0]         i_data;
    logic                      i_flush;
    logic [N_BYTES*BYTE_W-1:0] o_data;
    logic                      o_frame_stb;
    logic [CntW-1:0]           o_count;
    logic                      o_timeout;

    // Byte source: drives bytes and flush, observes the published frame.
    modport master (
        output i_valid, i_data, i_flush,
        input  o_data, o_frame_stb, o_count, o_timeout
    );

    // Assembler side.
    modport slave (
        input  i_valid, i_data, i_flush,
        output o_data, o_frame_stb, o_count, o_timeout
    );
endinterface

// File: rtl/lcd_frame_assembler.sv
// Collects N_BYTES received bytes in a shadow buffer and publishes them atomically as one frame.
// Partial frames are dropped on flush or after TIMEOUT_CYC idle clocks (0 disables the timer).
module lcd_frame_assembler #(
    parameter int unsigned BYTE_W      = 8,
    parameter int unsigned N_BYTES     = 32,
    parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    lcd_frame_assembler_if.slave bus
);
    localparam int unsigned     CntW    = $clog2(N_BYTES + 1);
    localparam logic [CntW-1:0] LastIdx = CntW'(N_BYTES - 1);

    typedef enum logic [0:0] {StEmpty, StFill} state_e;

    state_e                    state_q;
    logic [CntW-1:0]           count_q;
    // The final byte goes straight to the output, so only N_BYTES-1 slots are buffered.
    logic [BYTE_W-1:0]         shadow_q [N_BYTES-1];
    logic [N_BYTES*BYTE_W-1:0] data_q;
    logic                      frame_stb_q;
    logic                      timeout_q;
    logic                      timer_expired;

    generate
        if (TIMEOUT_CYC > 0) begin : g_timer
            localparam int unsigned     TmrW    = $clog2(TIMEOUT_CYC + 1);
            localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYC - 1);

            logic [TmrW-1:0] timer_q;
            logic            idle_cycle;

            // A byte or flush on the expiry clock takes priority over the drop.
            assign idle_cycle    = (state_q == StFill) && !bus.i_valid && !bus.i_flush;
            assign timer_expired = idle_cycle && (timer_q == TmrLast);

            // Idle timer: counts idle FILL clocks, clears on any byte, flush or return to EMPTY.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    timer_q <= '0;
                end else if (idle_cycle && !timer_expired) begin
                    timer_q <= timer_q + 1'b1;
                end else begin
                    timer_q <= '0;
                end
            end
        end else begin : g_no_timer
            assign timer_expired = 1'b0;
        end
    endgenerate

    // Frame FSM: byte capture, atomic publish, flush and timeout drop, all outputs registered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StEmpty;
            count_q     <= '0;
            data_q      <= '0;
            frame_stb_q <= 1'b0;
            timeout_q   <= 1'b0;
            for (int k = 0; k < int'(N_BYTES) - 1; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            frame_stb_q <= 1'b0;
            timeout_q   <= 1'b0;
            if (bus.i_flush) begin
                state_q <= StEmpty;
                count_q <= '0;
            end else if (bus.i_valid) begin
                if (count_q == LastIdx) begin
                    for (int k = 0; k < int'(N_BYTES) - 1; k++) begin
                        data_q[k*BYTE_W +: BYTE_W] <= shadow_q[k];
                    end
                    data_q[(N_BYTES-1)*BYTE_W +: BYTE_W] <= bus.i_data;
                    frame_stb_q <= 1'b1;
                    count_q     <= '0;
                    state_q     <= StEmpty;
                end else begin
                    for (int k = 0; k < int'(N_BYTES) - 1; k++) begin
                        if (count_q == CntW'(k)) begin
                            shadow_q[k] <= bus.i_data;
                        end
                    end
                    count_q <= count_q + 1'b1;
                    state_q <= StFill;
                end
            end else if (timer_expired) begin
                count_q   <= '0;
                state_q   <= StEmpty;
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.o_data      = data_q;
    assign bus.o_frame_stb = frame_stb_q;
    assign bus.o_count     = count_q;
    assign bus.o_timeout   = timeout_q;
endmodule

// File: doc/lcd_frame_assembler.md
# lcd_frame_assembler

Parametrised byte-stream-to-frame assembler between the UART receiver and the LCD character driver. It counts incoming bytes internally and fills a shadow buffer. It publishes a complete N_BYTES frame atomically on a double-buffered output, so the LCD side never sees a half-written frame. Partial frames are discarded on an idle timeout or an explicit flush.

## Interface
- BYTE_W, 8, bits per received byte
- N_BYTES, 32, bytes per frame (≥2)
- TIMEOUT_CYC, 50_000_000, idle clocks before a partial frame is dropped; 0 disables the timeout
- i_clk  in  1  system clock, all state on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_valid  in  1  one-cycle strobe: i_data holds a new byte
- i_data  in  BYTE_W  received byte
- i_flush  in  1  discard the partial frame
- o_data  out  N_BYTES*BYTE_W  last published frame; byte k at [k*BYTE_W +: BYTE_W], byte 0 = first received
- o_frame_stb  out  1  one-cycle pulse, o_data updated this cycle
- o_count  out  $clog2(N_BYTES+1)  bytes held in the current partial frame
- o_timeout  out  1  one-cycle pulse, partial frame dropped by timeout

## Operation
- States: EMPTY (o_count=0) and FILL (1 ≤ o_count ≤ N_BYTES-1).
- Byte accept (i_valid=1, i_flush=0): the byte goes to shadow slot o_count, and o_count increments. EMPTY→FILL on the first byte.
- Last byte (i_valid with o_count=N_BYTES-1):
  - o_data takes shadow slots 0..N_BYTES-2 plus i_data in slot N_BYTES-1, all on the same edge.
  - o_frame_stb=1 and o_count=0, and the state returns to EMPTY.
- o_data changes only on frame completion. Shadow writes are invisible on o_data.
- Idle timer:
  - Counts clocks in FILL with no i_valid.
  - Clears on every accepted byte and on entry to EMPTY.
  - When it reaches TIMEOUT_CYC: o_count=0, o_timeout=1 for one cycle, state → EMPTY. o_data is unchanged.
  - Timer width is $clog2(TIMEOUT_CYC+1). With TIMEOUT_CYC=0 the timer is never instantiated, and o_timeout is tied to 0.
- Flush: i_flush=1 forces o_count=0 and state EMPTY next edge. o_data is unchanged and no strobe is raised. i_flush in EMPTY is a no-op.
- Priorities within one cycle:
  - i_flush with i_valid: the flush wins and the byte is dropped.
  - i_valid with timer expiry: the byte wins. It is accepted, the timer clears, and there is no o_timeout.
  - i_flush with timer expiry: the flush wins, with no o_timeout.
- Shadow slots are not cleared on flush or timeout; stale contents are overwritten before reuse.

## Timing
- Reset values (asynchronous, immediate on i_rst=1):
  - o_data=0, o_count=0, o_frame_stb=0, o_timeout=0.
  - Shadow buffer = 0, timer = 0, state EMPTY.
- i_valid is ignored while i_rst=1.
- Latency:
  - o_count reflects a byte one clock after its i_valid.
  - o_data and o_frame_stb update one clock after the final byte's i_valid.
- Back-to-back i_valid on every clock is supported at full rate. A byte arriving the cycle after completion becomes byte 0 of the next frame.
- Timeout timing: o_timeout rises exactly TIMEOUT_CYC clocks after the last accepted byte, provided no i_valid or i_flush arrives in between.
- Reset mid-frame: the partial frame and the published frame are both lost and outputs return to reset values. After deassertion, the next i_valid is byte 0.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then 32 strobes with data 0x00..0x1F on consecutive clocks:
  - o_frame_stb pulses once, one clock after the 32nd strobe.
  - o_data[7:0]=0x00 and o_data[255:248]=0x1F.
  - o_count returns to 0.
- Double buffering: after frame A (all 0xAA), send 10 bytes of 0x55. o_data stays all 0xAA and o_count=10, with no strobe.
- Timeout (TIMEOUT_CYC=100): send 5 bytes, then idle.
  - o_timeout pulses exactly 100 clocks after the 5th byte, and o_count=0.
  - The next 32 bytes form a clean frame starting at slot 0.
- Boundary collisions:
  - i_valid on the exact expiry cycle: the byte is accepted, o_count increments, and there is no o_timeout.
  - i_flush together with i_valid: o_count=0 and the byte is dropped.
- Asynchronous i_rst asserted mid-clock after 20 bytes:
  - Outputs go to 0 immediately, before the next edge.
  - Post-reset, 32 bytes publish correctly.
- N_BYTES=4, BYTE_W=16, TIMEOUT_CYC=0:
  - A 4-word frame publishes to the 64-bit o_data.
  - A 1000-clock idle mid-frame never raises o_timeout.
